// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU take a fixed
// 34-cycle sequence (latch, 32 iterations, fix-up); MTHI/MTLO complete in one
// cycle. Signed operations work on operand magnitudes and correct the sign in
// the fix-up step.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_MD_Start,
    input  logic [2:0]       I_MD_Op,
    input  logic [WIDTH-1:0] I_MD_A,
    input  logic [WIDTH-1:0] I_MD_B,
    output logic [WIDTH-1:0] O_MD_HI,
    output logic [WIDTH-1:0] O_MD_LO,
    output logic             O_MD_Busy,
    output logic             O_MD_Done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    // Mul: {partial product high, multiplier shifting out}.
    // Div: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0]   orig_a;    // raw A, returned in HI on divide by zero
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic               is_div;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] acc_neg;

    // Operand magnitudes and one iteration of shift-add / restoring divide.
    always_comb begin
        is_signed = ~I_MD_Op[0];
        mag_a     = (is_signed && I_MD_A[WIDTH-1]) ? -I_MD_A : I_MD_A;
        mag_b     = (is_signed && I_MD_B[WIDTH-1]) ? -I_MD_B : I_MD_B;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = {1'b0, rem_sh} - {2'b00, opnd};
        acc_neg   = -acc;
    end

    // Sequencer, datapath registers and HI/LO.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            orig_a   <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_MD_Start) begin
                        case (I_MD_Op)
                            3'b100: hi <= I_MD_A;
                            3'b101: lo <= I_MD_A;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div   <= I_MD_Op[1];
                                neg_res  <= is_signed & (I_MD_A[WIDTH-1] ^ I_MD_B[WIDTH-1]);
                                neg_rem  <= is_signed & I_MD_Op[1] & I_MD_A[WIDTH-1];
                                div_zero <= I_MD_Op[1] & (I_MD_B == '0);
                                orig_a   <= I_MD_A;
                                opnd     <= I_MD_Op[1] ? mag_b : mag_a;
                                acc      <= {{WIDTH{1'b0}}, (I_MD_Op[1] ? mag_a : mag_b)};
                                cnt      <= '0;
                                state    <= I_MD_Op[1] ? DIV : MUL;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= FIX;
                end
                DIV: begin
                    if (!diff[WIDTH+1]) begin
                        acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= FIX;
                end
                default: begin  // FIX
                    if (!is_div) begin
                        {hi, lo} <= neg_res ? acc_neg : acc;
                    end else if (div_zero) begin
                        hi <= orig_a;
                        lo <= {WIDTH{1'b1}};
                    end else begin
                        lo <= neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign O_MD_HI   = hi;
    assign O_MD_LO   = lo;
    assign O_MD_Busy = (state != IDLE);
    assign O_MD_Done = done;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage. Consumes operands and control from the ID/EX pipeline register and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle sequence. Executes MTHI and MTLO in a single cycle.
- Exports Busy to the hazard unit, which stalls IF/ID/EX on any MFHI, MFLO or mul/div issued while the unit is busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; 2^CNT_W must equal WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- I_MD_Start  input  1  operation request, qualified by the EX stage being valid and not flushed.
- I_MD_Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-op.
- I_MD_A  input  WIDTH  rs operand, forwarded read_data1.
- I_MD_B  input  WIDTH  rt operand, forwarded read_data2.
- O_MD_HI  output  WIDTH  HI register.
- O_MD_LO  output  WIDTH  LO register.
- O_MD_Busy  output  1  high whenever state is not IDLE.
- O_MD_Done  output  1  one-cycle pulse when HI/LO have just been updated by a mul/div.

Behaviour:
- Reset: clock and reset are CLK and RESET; reset is asynchronous, active-high. While RESET is high: state=IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0, internal accumulators=0. Reset mid-operation abandons the operation and produces no Done.
- States: IDLE, MUL, DIV, FIX.
- IDLE, Start=1, Op=MTHI: HI<=A at that edge. Stay in IDLE, no Busy, no Done.
- IDLE, Start=1, Op=MTLO: LO<=A at that edge. Stay in IDLE, no Busy, no Done.
- IDLE, Start=1, Op=MULT/MULTU/DIV/DIVU (edge E0):
  - Latch operand magnitudes: for signed ops, the absolute value of each operand; for unsigned ops, the raw value.
  - Latch the result-negate flag (signs differ, signed ops only) and the remainder-negate flag (dividend negative, DIV only).
  - Latch the divide-by-zero flag (B==0).
  - Clear counter, then go to MUL or DIV.
- IDLE, Start=1, Op=110/111: ignored.
- MUL: radix-2 shift-add over a 2*WIDTH product, one multiplier bit per edge, edges E0+1..E0+32. Counter increments each edge. At counter==WIDTH-1 the unit goes to FIX.
- DIV: restoring division, one quotient bit per edge, edges E0+1..E0+32:
  - shift the remainder left with the next dividend bit;
  - trial-subtract the divisor;
  - keep the difference and set the quotient bit if it is non-negative.
  - Then go to FIX as in MUL.
- FIX, edge E0+33:
  - Mul: {HI,LO}<=product, two's-complement negated over 2*WIDTH bits if the negate flag is set.
  - Div: LO<=quotient, negated if the result-negate flag is set. HI<=remainder, negated if the remainder-negate flag is set.
  - Divide by zero overrides the above: HI<=A (original value), LO<=32'hFFFFFFFF, regardless of sign.
  - State goes to IDLE. Done=1 during the cycle following E0+33.
- Latency: Busy is high in the cycles after E0 through E0+33 (33 cycles). HI/LO are valid from E0+33 onward.
- Start while Busy: ignored, including MTHI/MTLO. The hazard unit is responsible for never issuing it; the unit must not corrupt the in-flight operation.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude method; no exception is raised.
- HI/LO hold their values in all other cycles. Outputs are direct register outputs with no combinational path from inputs.

Test Plan:
- Reset then MULTU A=FFFFFFFF B=FFFFFFFF at E0 -> Busy high for 33 cycles; at E0+33 HI=FFFFFFFE, LO=00000001; Done pulses exactly once.
- MULT A=FFFFFFFD (-3) B=00000005 -> HI=FFFFFFFF, LO=FFFFFFF1. Then MULT A=80000000 B=80000000 -> HI=40000000, LO=00000000.
- DIV A=FFFFFFF9 (-7) B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU A=00000007 B=00000002 -> LO=00000003, HI=00000001.
- DIVU A=12345678 B=0 -> HI=12345678, LO=FFFFFFFF, same 34-cycle timing. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- MTHI A=CAFEBABE then MTLO A=DEADBEEF in consecutive cycles -> HI/LO update at the same edges, Busy stays 0. A MULTU issued at E0+5 of a running DIV is ignored: the result equals the DIV result alone.
- Assert RESET at E0+10 of a MULT -> HI=LO=0 and Busy=0 immediately, no Done. A new MULTU 3*4 after release -> LO=0000000C, HI=0.
